ex_muldiv_ctrl: RTL and testbench

- Iterative multiply/divide sequencer beside the EX stage; owns the HI/LO register pair.
- Accepts MULT/MULTU/DIV/DIVU from EX and runs a 32-iteration shift-add or restoring-divide datapath.
- Raises a stall request so the pipeline holds the instruction until the result is ready.
- Services MTHI/MTLO writes and provides MFHI/MFLO read data to the EX result mux.

---
 rtl/ex_muldiv_ctrl_if.sv | 26 ++
 rtl/ex_muldiv_ctrl.sv | 163 ++++++++++++++++
 tb/tb_ex_muldiv_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_muldiv_ctrl_if.sv
// Handshake between the EX stage and the multiply/divide sequencer.
// EX drives the instruction side and reads back stall, HI/LO and move data.
interface ex_muldiv_ctrl_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [5:0]            funct;
  logic [DATA_WIDTH-1:0] operand_1;
  logic [DATA_WIDTH-1:0] operand_2;
  logic                  flush;
  logic                  stall_req;
  logic                  busy;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic [DATA_WIDTH-1:0] mf_data;

  modport master (
    output start, funct, operand_1, operand_2, flush,
    input  stall_req, busy, hi, lo, mf_data
  );

  modport slave (
    input  start, funct, operand_1, operand_2, flush,
    output stall_req, busy, hi, lo, mf_data
  );
endinterface

// File: rtl/ex_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one shift-add or
// restoring-divide step per cycle, with a stall request holding the pipeline.
module ex_muldiv_ctrl #(
  parameter int         DATA_WIDTH  = 32,
  parameter logic [5:0] FUNCT_MULT  = 6'h18,
  parameter logic [5:0] FUNCT_MULTU = 6'h19,
  parameter logic [5:0] FUNCT_DIV   = 6'h1A,
  parameter logic [5:0] FUNCT_DIVU  = 6'h1B,
  parameter logic [5:0] FUNCT_MFHI  = 6'h10,
  parameter logic [5:0] FUNCT_MTHI  = 6'h11,
  parameter logic [5:0] FUNCT_MFLO  = 6'h12,
  parameter logic [5:0] FUNCT_MTLO  = 6'h13
) (
  input  logic            clk,
  input  logic            rst_n,
  ex_muldiv_ctrl_if.slave bus
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;
  logic [W-1:0]    op_a_reg;
  logic [W-1:0]    op_b_reg;
  logic [2*W-1:0]  acc_reg;
  logic            neg_res_reg;
  logic            neg_a_reg;
  logic [W-1:0]    hi_reg;
  logic [W-1:0]    lo_reg;

  logic            is_mul;
  logic            is_div;
  logic            is_signed;
  logic            a_neg;
  logic            b_neg;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic            accept;
  logic            last_step;

  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [2*W-1:0]  prod_fix;
  logic [2*W:0]    div_shift;
  logic [W+1:0]    div_diff;
  logic            div_ok;
  logic [2*W-1:0]  div_next;
  logic [W-1:0]    quo_fix;
  logic [W-1:0]    rem_fix;

  assign is_mul    = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_MULTU);
  assign is_div    = (bus.funct == FUNCT_DIV)  || (bus.funct == FUNCT_DIVU);
  assign is_signed = (bus.funct == FUNCT_MULT) || (bus.funct == FUNCT_DIV);

  // Magnitudes: negating 0x80000000 yields 2^31 when read unsigned.
  assign a_neg = is_signed & bus.operand_1[W-1];
  assign b_neg = is_signed & bus.operand_2[W-1];
  assign mag_a = a_neg ? -bus.operand_1 : bus.operand_1;
  assign mag_b = b_neg ? -bus.operand_2 : bus.operand_2;

  assign accept    = (state_reg == IDLE) & bus.start & ~bus.flush;
  assign last_step = (cnt_reg == CW'(W - 1));

  // Shift-add: acc = {partial product, remaining multiplier bits}.
  assign mul_sum  = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, op_a_reg} : {(W+1){1'b0}});
  assign mul_next = {mul_sum, acc_reg[W-1:1]};
  assign prod_fix = neg_res_reg ? -mul_next : mul_next;

  // Restoring divide: acc = {remainder, dividend bits shifting into quotient}.
  assign div_shift = {acc_reg, 1'b0};
  assign div_diff  = {1'b0, div_shift[2*W:W]} - {2'b00, op_b_reg};
  assign div_ok    = ~div_diff[W+1];
  assign div_next  = {(div_ok ? div_diff[W-1:0] : div_shift[2*W-1:W]), div_shift[W-1:1], div_ok};
  assign quo_fix   = neg_res_reg ? -div_next[W-1:0]   : div_next[W-1:0];
  assign rem_fix   = neg_a_reg   ? -div_next[2*W-1:W] : div_next[2*W-1:W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      op_a_reg    <= '0;
      op_b_reg    <= '0;
      acc_reg     <= '0;
      neg_res_reg <= 1'b0;
      neg_a_reg   <= 1'b0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              op_a_reg    <= mag_a;
              op_b_reg    <= mag_b;
              neg_res_reg <= a_neg ^ b_neg;
              neg_a_reg   <= a_neg;
              acc_reg     <= {{W{1'b0}}, mag_b};
              cnt_reg     <= '0;
              state_reg   <= MUL;
            end else if (is_div && (bus.operand_2 != '0)) begin
              op_a_reg    <= mag_a;
              op_b_reg    <= mag_b;
              neg_res_reg <= a_neg ^ b_neg;
              neg_a_reg   <= a_neg;
              acc_reg     <= {{W{1'b0}}, mag_a};
              cnt_reg     <= '0;
              state_reg   <= DIV;
            end else if (is_div) begin
              // Divide by zero resolves immediately with a fixed result.
              lo_reg    <= '1;
              hi_reg    <= bus.operand_1;
              state_reg <= DONE;
            end else if (bus.funct == FUNCT_MTHI) begin
              hi_reg <= bus.operand_1;
            end else if (bus.funct == FUNCT_MTLO) begin
              lo_reg <= bus.operand_1;
            end
          end
        end
        MUL: begin
          if (bus.flush) begin
            state_reg <= IDLE;
          end else begin
            acc_reg <= mul_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (last_step) begin
              {hi_reg, lo_reg} <= prod_fix;
              state_reg        <= DONE;
            end
          end
        end
        DIV: begin
          if (bus.flush) begin
            state_reg <= IDLE;
          end else begin
            acc_reg <= div_next;
            cnt_reg <= cnt_reg + 1'b1;
            if (last_step) begin
              lo_reg    <= quo_fix;
              hi_reg    <= rem_fix;
              state_reg <= DONE;
            end
          end
        end
        default: begin
          // DONE: result already committed; never re-triggers.
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (state_reg == MUL) | (state_reg == DIV);
  assign bus.stall_req = ~bus.flush &
                         (((state_reg == IDLE) & bus.start & (is_mul | is_div)) |
                          (state_reg == MUL) | (state_reg == DIV));
  assign bus.hi        = hi_reg;
  assign bus.lo        = lo_reg;
  assign bus.mf_data   = (bus.funct == FUNCT_MFHI) ? hi_reg :
                         (bus.funct == FUNCT_MFLO) ? lo_reg : '0;
endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Bench for ex_muldiv_ctrl: vector table, random ops against a reference
// model, and hand sequences for flush, reset and HI/LO moves.
module tb_ex_muldiv_ctrl;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_ctrl_if bus();
  ex_muldiv_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          stall;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa;
    longint      sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e.stall = 33;
    e.hi = '0;
    e.lo = '0;
    p = '0;
    if ((f == F_DIV || f == F_DIVU) && b == 32'd0) begin
      e.hi = a;
      e.lo = 32'hFFFFFFFF;
      e.stall = 1;
    end else begin
      case (f)
        F_MULT:  begin p = 64'(sa * sb); e.hi = p[63:32]; e.lo = p[31:0]; end
        F_MULTU: begin p = {32'd0, a} * {32'd0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
        F_DIV:   begin e.lo = 32'(sa / sb); e.hi = 32'(sa % sb); end
        default: begin e.lo = a / b; e.hi = a % b; end
      endcase
    end
    return e;
  endfunction

  // Drive one mul/div, hold start until DONE, then confirm it does not re-run.
  task automatic run_op(input string name, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b, input exp_t e);
    int   n;
    exp_t got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct = f;
    bus.operand_1 = a;
    bus.operand_2 = b;
    sb_q.push_back(e);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      #1;
      if (!bus.stall_req) break;
      n++;
      if (n == 2) check32({name, " busy_mid"}, 32'(bus.busy), 32'd1);
      @(negedge clk);
    end
    got = sb_q.pop_front();
    check32({name, " stall_cycles"}, 32'(n), 32'(got.stall));
    check32({name, " hi"}, bus.hi, got.hi);
    check32({name, " lo"}, bus.lo, got.lo);
    model_hi = got.hi;
    model_lo = got.lo;
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check32({name, " no_retrigger"}, 32'(bus.busy), 32'd0);
    $display("op %s funct=%h a=%h b=%h -> hi=%h lo=%h stall=%0d", name, f, a, b, bus.hi, bus.lo, n);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[1] = '{F_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 33};
    vecs[2] = '{F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
    vecs[3] = '{F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[4] = '{F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[5] = '{F_DIVU,  32'h00001234, 32'h00000000, 32'h00001234, 32'hFFFFFFFF, 1};
    vecs[6] = '{F_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
    vecs[7] = '{F_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 33};
    vecs[8] = '{F_DIV,   32'h80000000, 32'h00000000, 32'h80000000, 32'hFFFFFFFF, 1};

    bus.start = 1'b0;
    bus.funct = '0;
    bus.operand_1 = '0;
    bus.operand_2 = '0;
    bus.flush = 1'b0;

    repeat (2) @(negedge clk);
    check32("reset hi", bus.hi, 32'd0);
    check32("reset lo", bus.lo, 32'd0);
    check32("reset busy", 32'(bus.busy), 32'd0);
    check32("reset stall", 32'(bus.stall_req), 32'd0);
    rst_n = 1'b1;
    $display("reset released");

    for (int i = 0; i < 9; i++) begin
      exp_t e;
      e.hi = vecs[i].hi;
      e.lo = vecs[i].lo;
      e.stall = vecs[i].stall;
      run_op($sformatf("vec%0d", i), vecs[i].funct, vecs[i].a, vecs[i].b, e);
    end

    for (int i = 0; i < 8; i++) begin
      logic [5:0]  f;
      logic [31:0] a;
      logic [31:0] b;
      case ($urandom_range(0, 3))
        0: f = F_MULT;
        1: f = F_MULTU;
        2: f = F_DIV;
        default: f = F_DIVU;
      endcase
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (f == F_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
      run_op($sformatf("rnd%0d", i), f, a, b, model(f, a, b));
    end

    // MTHI preload: no stall, HI written on the accept edge.
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct = F_MTHI;
    bus.operand_1 = 32'h0000AAAA;
    #1;
    check32("mthi stall", 32'(bus.stall_req), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check32("mthi hi", bus.hi, 32'h0000AAAA);
    model_hi = 32'h0000AAAA;
    $display("op mthi hi=%h", bus.hi);

    // Flush a DIVU when cnt reaches 10.
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct = F_DIVU;
    bus.operand_1 = 32'd1000;
    bus.operand_2 = 32'd3;
    for (int i = 0; i < 11; i++) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    check32("flush stall_drop", 32'(bus.stall_req), 32'd0);
    @(negedge clk);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    #1;
    check32("flush busy", 32'(bus.busy), 32'd0);
    check32("flush hi_kept", bus.hi, model_hi);
    check32("flush lo_kept", bus.lo, model_lo);
    repeat (3) @(negedge clk);
    check32("flush hi_late", bus.hi, model_hi);
    $display("op divu_flush hi=%h lo=%h", bus.hi, bus.lo);

    // Asynchronous reset in the middle of a MULTU.
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct = F_MULTU;
    bus.operand_1 = 32'd3;
    bus.operand_2 = 32'd4;
    repeat (5) @(negedge clk);
    #1;
    check32("midmul busy", 32'(bus.busy), 32'd1);
    #1;
    rst_n = 1'b0;
    bus.start = 1'b0;
    #1;
    check32("midrst hi", bus.hi, 32'd0);
    check32("midrst lo", bus.lo, 32'd0);
    check32("midrst busy", 32'(bus.busy), 32'd0);
    check32("midrst stall", 32'(bus.stall_req), 32'd0);
    model_hi = '0;
    model_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    $display("op multu_reset hi=%h lo=%h", bus.hi, bus.lo);

    // MTLO then MFLO/MFHI read-back through mf_data.
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct = F_MTLO;
    bus.operand_1 = 32'h00005555;
    #1;
    check32("mtlo stall", 32'(bus.stall_req), 32'd0);
    @(negedge clk);
    bus.funct = F_MFLO;
    #1;
    check32("mflo data", bus.mf_data, 32'h00005555);
    bus.funct = F_MFHI;
    #1;
    check32("mfhi data", bus.mf_data, model_hi);
    bus.funct = F_MULT;
    bus.start = 1'b0;
    #1;
    check32("mf other", bus.mf_data, 32'd0);
    $display("op mtlo/mflo lo=%h", bus.lo);

    // Flush in IDLE suppresses an MTHI.
    @(negedge clk);
    bus.start = 1'b1;
    bus.funct = F_MTHI;
    bus.operand_1 = 32'h0000DEAD;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    check32("idle_flush hi", bus.hi, model_hi);
    $display("op mthi_flushed hi=%h", bus.hi);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end
endmodule
